// File: rtl/mqnic_rx_queue_map_req.sv
// In-order reorder buffer between per-packet receive requests and the queue map.
// Requests get a slot tag, the map answers by tag, and results leave in accept order.
module mqnic_rx_queue_map_req #(
    parameter int ID_WIDTH          = 1,
    parameter int DEST_WIDTH        = 11,
    parameter int HASH_WIDTH        = 32,
    parameter int QUEUE_INDEX_WIDTH = 10,
    parameter int LEN_WIDTH         = 16,
    parameter int TAG_WIDTH         = 8,
    parameter int DEPTH             = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [ID_WIDTH-1:0]          s_req_id,
    input  logic [DEST_WIDTH-1:0]        s_req_dest,
    input  logic [HASH_WIDTH-1:0]        s_req_hash,
    input  logic [LEN_WIDTH-1:0]         s_req_len,
    input  logic                         s_req_valid,
    output logic                         s_req_ready,

    output logic [ID_WIDTH-1:0]          map_req_id,
    output logic [DEST_WIDTH-1:0]        map_req_dest,
    output logic [HASH_WIDTH-1:0]        map_req_hash,
    output logic [TAG_WIDTH-1:0]         map_req_tag,
    output logic                         map_req_valid,

    input  logic [QUEUE_INDEX_WIDTH-1:0] map_resp_queue,
    input  logic [TAG_WIDTH-1:0]         map_resp_tag,
    input  logic                         map_resp_valid,

    output logic [QUEUE_INDEX_WIDTH-1:0] m_resp_queue,
    output logic [ID_WIDTH-1:0]          m_resp_id,
    output logic [LEN_WIDTH-1:0]         m_resp_len,
    output logic                         m_resp_valid,
    input  logic                         m_resp_ready,

    output logic [$clog2(DEPTH):0]       stat_inflight,
    output logic                         err_bad_tag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] occupancy;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] resp_idx;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] pending_next;
    logic [DEPTH-1:0] done_next;

    logic [ID_WIDTH-1:0]          id_mem    [DEPTH];
    logic [LEN_WIDTH-1:0]         len_mem   [DEPTH];
    logic [QUEUE_INDEX_WIDTH-1:0] queue_mem [DEPTH];

    logic accept;
    logic pop;
    logic tag_oob;
    logic resp_ok;

    assign occupancy = wr_ptr - rd_ptr;
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign resp_idx  = map_resp_tag[AW-1:0];

    assign s_req_ready = (occupancy != PW'(DEPTH));
    assign accept      = s_req_valid && s_req_ready;

    assign m_resp_valid = pending[rd_idx] && done[rd_idx];
    assign m_resp_queue = queue_mem[rd_idx];
    assign m_resp_id    = id_mem[rd_idx];
    assign m_resp_len   = len_mem[rd_idx];
    assign pop          = m_resp_valid && m_resp_ready;

    // Tag bits above the slot index must be zero for the tag to name a slot.
    if (TAG_WIDTH > AW) begin : g_oob
        assign tag_oob = |map_resp_tag[TAG_WIDTH-1:AW];
    end else begin : g_no_oob
        assign tag_oob = 1'b0;
    end

    // A head slot being popped is already done, so a same-cycle response to it is rejected here.
    assign resp_ok = map_resp_valid && !tag_oob
                  && pending[resp_idx] && !done[resp_idx];

    assign wr_ptr_next = wr_ptr + PW'(accept);
    assign rd_ptr_next = rd_ptr + PW'(pop);

    always_comb begin
        pending_next = pending;
        done_next    = done;
        if (pop) begin
            pending_next[rd_idx] = 1'b0;
            done_next[rd_idx]    = 1'b0;
        end
        if (resp_ok) begin
            done_next[resp_idx] = 1'b1;
        end
        if (accept) begin
            pending_next[wr_idx] = 1'b1;
            done_next[wr_idx]    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending       <= '0;
            done          <= '0;
            map_req_valid <= 1'b0;
            err_bad_tag   <= 1'b0;
            stat_inflight <= '0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            pending       <= pending_next;
            done          <= done_next;
            map_req_valid <= accept;
            err_bad_tag   <= map_resp_valid && !resp_ok;
            stat_inflight <= wr_ptr_next - rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_idx]  <= s_req_id;
            len_mem[wr_idx] <= s_req_len;
            map_req_id      <= s_req_id;
            map_req_dest    <= s_req_dest;
            map_req_hash    <= s_req_hash;
            map_req_tag     <= TAG_WIDTH'(wr_idx);
        end
        if (resp_ok) begin
            queue_mem[resp_idx] <= map_resp_queue;
        end
    end

endmodule

// File: tb/tb_mqnic_rx_queue_map_req.sv
// Scoreboard bench for mqnic_rx_queue_map_req: directed requests and map responses,
// monitors compare map requests and in-order results against queued expectations.
module tb_mqnic_rx_queue_map_req;

    localparam int DEPTH = 16;

    typedef struct {
        logic [7:0]  tag;
        logic [0:0]  id;
        logic [10:0] dest;
        logic [31:0] hash;
    } mreq_t;

    typedef struct {
        logic [9:0]  q;
        logic [0:0]  id;
        logic [15:0] len;
    } resp_t;

    typedef struct {
        logic [7:0] tag;
        int         due;
    } pm_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  s_req_id = '0;
    logic [10:0] s_req_dest = '0;
    logic [31:0] s_req_hash = '0;
    logic [15:0] s_req_len = '0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [0:0]  map_req_id;
    logic [10:0] map_req_dest;
    logic [31:0] map_req_hash;
    logic [7:0]  map_req_tag;
    logic        map_req_valid;
    logic [9:0]  map_resp_queue = '0;
    logic [7:0]  map_resp_tag = '0;
    logic        map_resp_valid = 1'b0;
    logic [9:0]  m_resp_queue;
    logic [0:0]  m_resp_id;
    logic [15:0] m_resp_len;
    logic        m_resp_valid;
    logic        m_resp_ready = 1'b1;
    logic [4:0]  stat_inflight;
    logic        err_bad_tag;

    always #5 clk = ~clk;

    mqnic_rx_queue_map_req dut (
        .clk            (clk),
        .rst            (rst),
        .s_req_id       (s_req_id),
        .s_req_dest     (s_req_dest),
        .s_req_hash     (s_req_hash),
        .s_req_len      (s_req_len),
        .s_req_valid    (s_req_valid),
        .s_req_ready    (s_req_ready),
        .map_req_id     (map_req_id),
        .map_req_dest   (map_req_dest),
        .map_req_hash   (map_req_hash),
        .map_req_tag    (map_req_tag),
        .map_req_valid  (map_req_valid),
        .map_resp_queue (map_resp_queue),
        .map_resp_tag   (map_resp_tag),
        .map_resp_valid (map_resp_valid),
        .m_resp_queue   (m_resp_queue),
        .m_resp_id      (m_resp_id),
        .m_resp_len     (m_resp_len),
        .m_resp_valid   (m_resp_valid),
        .m_resp_ready   (m_resp_ready),
        .stat_inflight  (stat_inflight),
        .err_bad_tag    (err_bad_tag)
    );

    int    n_chk   = 0;
    int    n_pass  = 0;
    int    err_cnt = 0;
    int    pops    = 0;
    int    tb_wr   = 0;
    mreq_t exp_map[$];
    resp_t exp_resp[$];

    function automatic logic [9:0] fq(input logic [7:0] t);
        return {t, 2'b01} ^ 10'h2a0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_map.delete();
        exp_resp.delete();
        tb_wr = 0;
    endtask

    task automatic push_exp(input logic [0:0] id, input logic [10:0] dest,
                            input logic [31:0] hash, input logic [15:0] len,
                            input logic [9:0] q);
        exp_map.push_back('{tag: 8'(tb_wr % DEPTH), id: id, dest: dest, hash: hash});
        exp_resp.push_back('{q: q, id: id, len: len});
        tb_wr++;
    endtask

    task automatic send(input logic [0:0] id, input logic [10:0] dest,
                        input logic [31:0] hash, input logic [15:0] len,
                        input logic [9:0] q);
        chk("send_ready", 64'(s_req_ready), 64'd1);
        push_exp(id, dest, hash, len, q);
        s_req_id    = id;
        s_req_dest  = dest;
        s_req_hash  = hash;
        s_req_len   = len;
        s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
    endtask

    task automatic resp(input logic [7:0] tag, input logic [9:0] q);
        map_resp_tag   = tag;
        map_resp_queue = q;
        map_resp_valid = 1'b1;
        tick();
        map_resp_valid = 1'b0;
    endtask

    mreq_t mm;
    resp_t rr;
    always @(negedge clk) begin
        if (map_req_valid) begin
            if (exp_map.size() == 0) begin
                n_chk++;
                $display("FAIL map_req_unexpected: actual tag %0d required none", map_req_tag);
            end else begin
                mm = exp_map.pop_front();
                chk("map_req_tag", 64'(map_req_tag), 64'(mm.tag));
                chk("map_req_fields", 64'({map_req_id, map_req_dest, map_req_hash}),
                    64'({mm.id, mm.dest, mm.hash}));
            end
        end
        if (m_resp_valid && m_resp_ready) begin
            pops++;
            if (exp_resp.size() == 0) begin
                n_chk++;
                $display("FAIL m_resp_unexpected: actual queue %0h required none", m_resp_queue);
            end else begin
                rr = exp_resp.pop_front();
                chk("m_resp_data", 64'({m_resp_queue, m_resp_id, m_resp_len}),
                    64'({rr.q, rr.id, rr.len}));
            end
        end
        if (err_bad_tag) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e0;
        int p0;
        int cyc;
        int sent;
        int target;
        pm_t pq[$];
        pm_t p;

        // reset state
        do_reset();
        chk("rst_req_ready", 64'(s_req_ready), 64'd1);
        chk("rst_m_resp_valid", 64'(m_resp_valid), 64'd0);
        chk("rst_map_req_valid", 64'(map_req_valid), 64'd0);
        chk("rst_err", 64'(err_bad_tag), 64'd0);
        chk("rst_inflight", 64'(stat_inflight), 64'd0);

        // single request, map answers 3 cycles after its request
        send(1'b0, 11'd5, 32'h1234, 16'd64, 10'h2a5);
        chk("t1_map_req_valid", 64'(map_req_valid), 64'd1);
        tick();
        tick();
        tick();
        chk("t1_no_resp_yet", 64'(m_resp_valid), 64'd0);
        resp(8'd0, 10'h2a5);
        chk("t1_resp_latency", 64'(m_resp_valid), 64'd1);
        tick();
        chk("t1_resp_gone", 64'(m_resp_valid), 64'd0);

        // fill all 16 slots back to back
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            send(1'(i), 11'(i * 7), 32'hC000_0000 + 32'(i), 16'(200 + i), fq(8'(i)));
        chk("t2_full_ready", 64'(s_req_ready), 64'd0);
        chk("t2_full_inflight", 64'(stat_inflight), 64'd16);
        s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        tick();
        chk("t2_full_hold", 64'(stat_inflight), 64'd16);
        for (int i = 0; i < DEPTH; i++) resp(8'(i), fq(8'(i)));
        tick();
        tick();
        chk("t2_drained", 64'(stat_inflight), 64'd0);

        // reverse-order map responses, in-order release
        do_reset();
        p0 = pops;
        for (int i = 0; i < 4; i++)
            send(1'(i), 11'(40 + i), 32'hBEEF_0000 + 32'(i), 16'(300 + i), fq(8'(i)));
        resp(8'd3, fq(8'd3));
        chk("t3_hold_after3", 64'(m_resp_valid), 64'd0);
        resp(8'd2, fq(8'd2));
        chk("t3_hold_after2", 64'(m_resp_valid), 64'd0);
        resp(8'd1, fq(8'd1));
        chk("t3_hold_after1", 64'(m_resp_valid), 64'd0);
        resp(8'd0, fq(8'd0));
        chk("t3_first_release", 64'(m_resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_count", 64'(pops - p0), 64'd4);

        // wrap-around: 40 packets, toggling result ready
        do_reset();
        cyc    = 0;
        sent   = 0;
        target = pops + 40;
        while (pops < target && cyc < 3000) begin
            if (sent < 40) begin
                s_req_id    = 1'(sent);
                s_req_dest  = 11'(sent * 3);
                s_req_hash  = 32'hA500_0000 + 32'(sent);
                s_req_len   = 16'(100 + sent);
                s_req_valid = 1'b1;
            end else begin
                s_req_valid = 1'b0;
            end
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                map_resp_tag   = p.tag;
                map_resp_queue = fq(p.tag);
                map_resp_valid = 1'b1;
            end else begin
                map_resp_valid = 1'b0;
            end
            m_resp_ready = (cyc % 2) == 1;
            if (s_req_valid && s_req_ready) begin
                push_exp(s_req_id, s_req_dest, s_req_hash, s_req_len, fq(8'(tb_wr % DEPTH)));
                sent++;
            end
            tick();
            cyc++;
            if (map_req_valid) pq.push_back('{tag: map_req_tag, due: cyc + 2});
        end
        s_req_valid    = 1'b0;
        map_resp_valid = 1'b0;
        m_resp_ready   = 1'b1;
        chk("t4_sent", 64'(sent), 64'd40);
        chk("t4_delivered", 64'(pops), 64'(target));
        tick();

        // idle-slot, duplicate and out-of-range tags
        do_reset();
        e0 = err_cnt;
        for (int i = 0; i < 3; i++)
            send(1'(i), 11'(600 + i), 32'h5A5A_0000 + 32'(i), 16'(500 + i), fq(8'(i)));
        resp(8'd2, fq(8'd2));
        chk("t5_good_no_err", 64'(err_bad_tag), 64'd0);
        resp(8'd7, 10'h111);
        chk("t5_idle_err", 64'(err_bad_tag), 64'd1);
        resp(8'd2, 10'h3ff);
        chk("t5_dup_err", 64'(err_bad_tag), 64'd1);
        resp(8'd200, 10'h222);
        chk("t5_oob_err", 64'(err_bad_tag), 64'd1);
        resp(8'd0, fq(8'd0));
        chk("t5_err_one_cycle", 64'(err_bad_tag), 64'd0);
        resp(8'd1, fq(8'd1));
        for (int i = 0; i < 4; i++) tick();
        chk("t5_err_count", 64'(err_cnt - e0), 64'd3);

        // reset with five in flight, stale responses afterwards
        do_reset();
        for (int i = 0; i < 5; i++)
            send(1'(i), 11'(700 + i), 32'h7700_0000 + 32'(i), 16'(900 + i), fq(8'(i)));
        chk("t6_inflight5", 64'(stat_inflight), 64'd5);
        do_reset();
        chk("t6_rst_ready", 64'(s_req_ready), 64'd1);
        chk("t6_rst_inflight", 64'(stat_inflight), 64'd0);
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            resp(8'(i), fq(8'(i)));
            chk("t6_stale_no_resp", 64'(m_resp_valid), 64'd0);
        end
        tick();
        chk("t6_stale_err_count", 64'(err_cnt - e0), 64'd5);
        send(1'b1, 11'd9, 32'hFACE_0001, 16'd77, 10'h0cc);
        resp(8'd0, 10'h0cc);
        tick();
        tick();

        chk("end_map_sb_empty", 64'(exp_map.size()), 64'd0);
        chk("end_resp_sb_empty", 64'(exp_resp.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
